fetch_queue_mp: RTL and testbench

FETCH_QUEUE_MP -- requirements
Module: fetch_queue_mp

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/fetch_queue_mp.sv | 111 +++++++++++
 tb/tb_fetch_queue_mp.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: fetch entry layout, fetch width and the
// ring-buffer index helper used by the fetch queue.
package cpu_defs;

   localparam int FETCH_NUM = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_taken;
   } fetch_entry_t;

   // Ring index add; depth must be a power of two so the mask is the modulo.
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned depth);
      return (base + off) & (depth - 1);
   endfunction

endpackage

// File: rtl/fetch_queue_mp.sv
// Multi-push / multi-pop fetch queue: circular flop buffer with per-cycle
// push of up to PUSH_NUM entries and pop of up to POP_NUM entries.
module fetch_queue_mp
   import cpu_defs::*;
#(
   parameter int  DEPTH    = 16,
   parameter int  PUSH_NUM = FETCH_NUM,
   parameter int  POP_NUM  = 2,
   parameter int  RESERVE  = 1,
   parameter type dtype    = fetch_entry_t
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         stall_push,
   input  logic                         push_delayslot,
   input  logic [$clog2(PUSH_NUM+1)-1:0] push_num,
   input  dtype                         data_push [PUSH_NUM],
   input  logic [$clog2(POP_NUM+1)-1:0]  pop_num,
   output dtype                         data_pop [POP_NUM],
   output logic [POP_NUM-1:0]           pop_valid,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow_err
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int SW  = CW + 1;
   localparam int PSW = $clog2(PUSH_NUM+1);

   // Handshake: producer offers push_num entries with no ready signal; it must
   // watch full (or use push_delayslot for reserved room) and learns of a drop
   // only through the sticky overflow_err. Consumer sees pop_valid/data_pop and
   // acknowledges pop_num entries in the same cycle; acks beyond count are ignored.

   dtype          mem [DEPTH];
   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;

   logic [CW-1:0] free;
   logic [CW-1:0] pop_eff;
   logic [SW-1:0] room;
   logic [SW-1:0] need_normal;
   logic [SW-1:0] need_delay;
   logic          push_req;
   logic          push_acc;
   logic          push_rej;

   always_comb begin
      free        = CW'(DEPTH) - count_q;
      pop_eff     = (CW'(pop_num) > count_q) ? count_q : CW'(pop_num);
      // Slots released by this cycle's pop are usable by this cycle's push.
      room        = SW'(free) + SW'(pop_eff);
      need_delay  = SW'(push_num);
      need_normal = SW'(push_num) + SW'(RESERVE);
      push_req    = ~stall_push & ~flush & (push_num != '0);
      push_acc    = push_req & ((room >= need_normal) |
                                (push_delayslot & (room >= need_delay)));
      push_rej    = push_req & ~push_acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q <= AW'(wrap_add(32'(head_q), 32'(pop_eff), DEPTH));
         if (push_acc) begin
            tail_q  <= AW'(wrap_add(32'(tail_q), 32'(push_num), DEPTH));
            count_q <= count_q + CW'(push_num) - pop_eff;
         end else begin
            count_q <= count_q - pop_eff;
         end
         if (push_rej) overflow_q <= 1'b1;
      end
   end

   // Storage holds no state of its own meaning; validity lives in count_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PUSH_NUM; i++) begin
         if (push_acc && (PSW'(i) < push_num))
            mem[AW'(wrap_add(32'(tail_q), 32'(i), DEPTH))] <= data_push[i];
      end
   end

   always_comb begin
      for (int i = 0; i < POP_NUM; i++) begin
         pop_valid[i] = (CW'(i) < count_q);
         data_pop[i]  = mem[AW'(wrap_add(32'(head_q), 32'(i), DEPTH))];
      end
   end

   assign full         = (SW'(free) < SW'(PUSH_NUM + RESERVE));
   assign empty        = (count_q == '0);
   assign count        = count_q;
   assign overflow_err = overflow_q;

   count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
                                    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue_mp.sv
// Directed plus randomized check of fetch_queue_mp against a queue-based
// reference model of occupancy, ordering, reserve and overflow rules.
module tb_fetch_queue_mp;
   import cpu_defs::*;

   localparam int DEPTH    = 16;
   localparam int PUSH_NUM = 3;
   localparam int POP_NUM  = 2;
   localparam int RESERVE  = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         stall_push = 1'b0;
   logic         push_delayslot = 1'b0;
   logic [1:0]   push_num = '0;
   fetch_entry_t data_push [PUSH_NUM];
   logic [1:0]   pop_num = '0;
   fetch_entry_t data_pop [POP_NUM];
   logic [1:0]   pop_valid;
   logic         full;
   logic         empty;
   logic [4:0]   count;
   logic         overflow_err;

   fetch_queue_mp #(
      .DEPTH(DEPTH), .PUSH_NUM(PUSH_NUM), .POP_NUM(POP_NUM), .RESERVE(RESERVE),
      .dtype(fetch_entry_t)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .stall_push(stall_push),
      .push_delayslot(push_delayslot), .push_num(push_num), .data_push(data_push),
      .pop_num(pop_num), .data_pop(data_pop), .pop_valid(pop_valid), .full(full),
      .empty(empty), .count(count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   fetch_entry_t model_q [$];
   bit           model_ovf = 1'b0;
   bit           last_acc  = 1'b0;
   int           total = 0;
   int           bad   = 0;
   int unsigned  seq   = 0;

   function automatic fetch_entry_t mk_entry();
      fetch_entry_t e;
      seq++;
      e.pc         = seq * 4;
      e.inst       = $urandom;
      e.pred_taken = 1'($urandom_range(0, 1));
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit f, input bit s, input bit ds, input int pn, input int pp);
      flush          = f;
      stall_push     = s;
      push_delayslot = ds;
      push_num       = 2'(pn);
      pop_num        = 2'(pp);
      for (int i = 0; i < PUSH_NUM; i++) data_push[i] = mk_entry();
   endtask

   // Reference behaviour: a FIFO of entries, updated once per rising edge.
   task automatic model_step();
      int n, pe, fr, pn;
      bit req;
      last_acc = 1'b0;
      if (flush) begin
         model_q.delete();
         return;
      end
      n   = model_q.size();
      pn  = int'(push_num);
      pe  = (int'(pop_num) < n) ? int'(pop_num) : n;
      fr  = DEPTH - n + pe;
      req = !stall_push && pn != 0;
      last_acc = req && ((fr >= pn + RESERVE) || (push_delayslot && fr >= pn));
      repeat (pe) void'(model_q.pop_front());
      if (last_acc) for (int i = 0; i < pn; i++) model_q.push_back(data_push[i]);
      if (req && !last_acc) model_ovf = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      int n;
      logic [1:0] pv;
      n = model_q.size();
      for (int i = 0; i < POP_NUM; i++) pv[i] = (i < n);
      chk({tag, ".count"}, 128'(count), 128'(n));
      chk({tag, ".empty"}, 128'(empty), 128'(n == 0));
      chk({tag, ".full"}, 128'(full), 128'((DEPTH - n) < (PUSH_NUM + RESERVE)));
      chk({tag, ".ovf"}, 128'(overflow_err), 128'(model_ovf));
      chk({tag, ".pop_valid"}, 128'(pop_valid), 128'(pv));
      for (int i = 0; i < POP_NUM; i++)
         if (i < n) chk($sformatf("%s.data_pop%0d", tag, i), 128'(data_pop[i]), 128'(model_q[i]));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   initial begin
      fetch_entry_t ea, eb, ec;
      int pushed, guard;

      drive(0, 0, 0, 0, 0);
      #2;
      check_outputs("reset");
      chk("reset.full0", 128'(full), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Single push of A,B,C into an empty queue.
      drive(0, 0, 0, 3, 0);
      ea = data_push[0];
      eb = data_push[1];
      step("single");
      chk("single.count", 128'(count), 128'(3));
      chk("single.pv", 128'(pop_valid), 128'(2'b11));
      chk("single.dp0", 128'(data_pop[0]), 128'(ea));
      chk("single.dp1", 128'(data_pop[1]), 128'(eb));

      // Fill to 13, then exercise the reserve.
      repeat (3) begin drive(0, 0, 0, 3, 0); step("fill"); end
      drive(0, 0, 0, 1, 0);
      step("fill13");
      chk("fill.count13", 128'(count), 128'(13));
      drive(0, 0, 0, 3, 0);
      step("reserve_rej");
      chk("reserve.rej_count", 128'(count), 128'(13));
      chk("reserve.rej_ovf", 128'(overflow_err), 128'(1));
      drive(0, 0, 1, 3, 0);
      step("reserve_ds");
      chk("reserve.ds_count", 128'(count), 128'(16));

      // Push and pop together while full.
      drive(0, 0, 0, 0, 2);
      step("to14");
      chk("pushpop.full_before", 128'(full), 128'(1));
      drive(0, 0, 0, 2, 2);
      step("pushpop");
      chk("pushpop.count", 128'(count), 128'(14));

      // Drain to one entry, then over-acknowledge.
      repeat (6) begin drive(0, 0, 0, 0, 2); step("drain"); end
      drive(0, 0, 0, 0, 1);
      step("drain1");
      chk("overack.pre", 128'(count), 128'(1));
      drive(0, 0, 0, 0, 2);
      step("overack");
      chk("overack.count", 128'(count), 128'(0));
      chk("overack.empty", 128'(empty), 128'(1));
      drive(0, 0, 0, 1, 0);
      ec = data_push[0];
      step("overack_push");
      chk("overack.head", 128'(data_pop[0]), 128'(ec));

      // Stream 37 entries through the ring with continuous pops.
      pushed = 0;
      guard  = 0;
      while (pushed < 37 && guard < 200) begin
         int pn;
         pn = $urandom_range(1, 3);
         if (pn > 37 - pushed) pn = 37 - pushed;
         drive(0, 0, 0, pn, 2);
         step("wrap");
         if (last_acc) pushed += pn;
         guard++;
      end
      chk("wrap.all_pushed", 128'(pushed), 128'(37));
      guard = 0;
      while (model_q.size() > 0 && guard < 50) begin
         drive(0, 0, 0, 0, 2);
         step("wrap_drain");
         guard++;
      end
      chk("wrap.empty", 128'(empty), 128'(1));

      // Randomized traffic.
      for (int c = 0; c < 300; c++) begin
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
         step("rand");
      end

      // Flush beats simultaneous push and pop.
      drive(1, 0, 0, 0, 0);
      step("flush_pre");
      drive(0, 0, 0, 3, 0);
      step("flush_fill");
      drive(0, 0, 0, 2, 0);
      step("flush_fill");
      chk("flush.count5", 128'(count), 128'(5));
      drive(1, 0, 0, 3, 2);
      step("flush");
      chk("flush.count", 128'(count), 128'(0));
      chk("flush.pv", 128'(pop_valid), 128'(0));

      // Asynchronous reset mid-stream.
      drive(0, 0, 0, 3, 0);
      step("rst_fill");
      drive(0, 0, 0, 3, 1);
      @(posedge clk);
      model_step();
      #3;
      rst_n = 1'b0;
      #1;
      model_q.delete();
      model_ovf = 1'b0;
      check_outputs("async_rst");
      chk("async_rst.full", 128'(full), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 2, 0);
      ea = data_push[0];
      step("post_rst");
      chk("post_rst.count", 128'(count), 128'(2));
      chk("post_rst.dp0", 128'(data_pop[0]), 128'(ea));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
